// File: rtl/nvdla_pdp_rdma_pkg.sv
// Shared constants and status encodings for the PDP RDMA register-group logic.
package nvdla_pdp_rdma_pkg;

  localparam int NUM_GRP = 2;

  typedef enum logic [1:0] {
    GRP_IDLE    = 2'd0,
    GRP_RUNNING = 2'd1,
    GRP_PENDING = 2'd2
  } grp_status_e;

  // An enabled group is RUNNING when hardware owns it and PENDING when it is queued.
  function automatic grp_status_e grp_status(input logic op_en, input logic is_consumer);
    if (!op_en) begin
      return GRP_IDLE;
    end
    if (is_consumer) begin
      return GRP_RUNNING;
    end
    return GRP_PENDING;
  endfunction

endpackage

// File: rtl/nvdla_grp_op_en_flop.sv
// Single register group's OP_ENABLE bit: software sets it, hardware clears it
// on layer completion, and a set attempt on an already-enabled group is
// flagged as busy instead of being applied.
module nvdla_grp_op_en_flop
  import nvdla_pdp_rdma_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_wr,
  input  logic i_wr_data,
  input  logic i_clr,
  output logic o_op_en,
  output logic o_busy
);

  logic r_op_en;
  logic w_set;

  // A write of 0 is ignored: software has no way to abort a running layer.
  assign w_set   = i_wr & i_wr_data & ~r_op_en;
  assign o_busy  = i_wr & i_wr_data & r_op_en;
  assign o_op_en = r_op_en;

  // Enable bit: hardware clear wins; set and clear are exclusive in practice
  // because clear only happens while the bit is 1 and set only while it is 0.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_op_en <= 1'b0;
    end else if (i_clr) begin
      r_op_en <= 1'b0;
    end else if (w_set) begin
      r_op_en <= 1'b1;
    end
  end

endmodule

// File: rtl/nvdla_pdp_rdma_grp_ctrl.sv
// Ping-pong group controller for the PDP read DMA: tracks which register group
// hardware is consuming, launches one layer per enabled group, hands over to
// the other group on completion and reports per-group status and errors.
module nvdla_pdp_rdma_grp_ctrl
  import nvdla_pdp_rdma_pkg::*;
(
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       producer,
  input  logic       op_en_wr_0,
  input  logic       op_en_wr_1,
  input  logic       op_en_wr_data,
  input  logic       op_done,
  input  logic       err_clr,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic       op_en_0,
  output logic       op_en_1,
  output logic       reg_wr_grp_sel,
  output logic       dp_grp_sel,
  output logic       dp_op_en,
  output logic       dp_op_start,
  output logic       done_intr_0,
  output logic       done_intr_1,
  output logic       err_wr_busy,
  output logic       err_spurious_done
);

  logic               r_consumer;
  logic               r_launched;
  logic               r_done_intr_0;
  logic               r_done_intr_1;
  logic               r_err_wr_busy;
  logic               r_err_spurious_done;

  logic [NUM_GRP-1:0] w_op_en;
  logic [NUM_GRP-1:0] w_busy;
  logic [NUM_GRP-1:0] w_clr;
  logic               w_dp_op_en;
  logic               w_dp_op_start;
  logic               w_done_acc;
  logic               w_done_spurious;

  // ---- per-group enable bits ----
  assign w_clr[0] = w_done_acc & ~r_consumer;
  assign w_clr[1] = w_done_acc &  r_consumer;

  nvdla_grp_op_en_flop u_op_en_0 (
    .i_clk     (nvdla_core_clk),
    .i_rstn    (nvdla_core_rstn),
    .i_wr      (op_en_wr_0),
    .i_wr_data (op_en_wr_data),
    .i_clr     (w_clr[0]),
    .o_op_en   (w_op_en[0]),
    .o_busy    (w_busy[0])
  );

  nvdla_grp_op_en_flop u_op_en_1 (
    .i_clk     (nvdla_core_clk),
    .i_rstn    (nvdla_core_rstn),
    .i_wr      (op_en_wr_1),
    .i_wr_data (op_en_wr_data),
    .i_clr     (w_clr[1]),
    .o_op_en   (w_op_en[1]),
    .o_busy    (w_busy[1])
  );

  // ---- datapath handshake ----
  assign w_dp_op_en      = r_consumer ? w_op_en[1] : w_op_en[0];
  assign w_dp_op_start   = w_dp_op_en & ~r_launched;
  assign w_done_acc      = op_done & w_dp_op_en;
  assign w_done_spurious = op_done & ~w_dp_op_en;

  // Ownership hand-over and launch tracking; completion clears launched so a
  // queued group starts on the very next cycle.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_consumer    <= 1'b0;
      r_launched    <= 1'b0;
      r_done_intr_0 <= 1'b0;
      r_done_intr_1 <= 1'b0;
    end else begin
      r_done_intr_0 <= w_done_acc & ~r_consumer;
      r_done_intr_1 <= w_done_acc &  r_consumer;
      if (w_done_acc) begin
        r_consumer <= ~r_consumer;
        r_launched <= 1'b0;
      end else if (w_dp_op_start) begin
        r_launched <= 1'b1;
      end
    end
  end

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_err_wr_busy       <= 1'b0;
      r_err_spurious_done <= 1'b0;
    end else if (err_clr) begin
      r_err_wr_busy       <= 1'b0;
      r_err_spurious_done <= 1'b0;
    end else begin
      if (|w_busy) begin
        r_err_wr_busy <= 1'b1;
      end
      if (w_done_spurious) begin
        r_err_spurious_done <= 1'b1;
      end
    end
  end

  // ---- outputs ----
  assign consumer          = r_consumer;
  assign op_en_0           = w_op_en[0];
  assign op_en_1           = w_op_en[1];
  assign status_0          = grp_status(w_op_en[0], ~r_consumer);
  assign status_1          = grp_status(w_op_en[1],  r_consumer);
  assign reg_wr_grp_sel    = producer;
  assign dp_grp_sel        = r_consumer;
  assign dp_op_en          = w_dp_op_en;
  assign dp_op_start       = w_dp_op_start;
  assign done_intr_0       = r_done_intr_0;
  assign done_intr_1       = r_done_intr_1;
  assign err_wr_busy       = r_err_wr_busy;
  assign err_spurious_done = r_err_spurious_done;

endmodule

// File: tb/tb_nvdla_pdp_rdma_grp_ctrl.sv
// Table-driven bench for the PDP RDMA group controller with a scoreboard queue
// of expected post-edge outputs.
module tb_nvdla_pdp_rdma_grp_ctrl;

  logic       clk = 1'b0;
  logic       rstn, producer, wr0, wr1, wdata, op_done, err_clr;
  logic       consumer, op_en_0, op_en_1, reg_wr_grp_sel, dp_grp_sel;
  logic       dp_op_en, dp_op_start, done_intr_0, done_intr_1;
  logic       err_wr_busy, err_spurious_done;
  logic [1:0] status_0, status_1;

  always #5 clk = ~clk;

  nvdla_pdp_rdma_grp_ctrl dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .producer          (producer),
    .op_en_wr_0        (wr0),
    .op_en_wr_1        (wr1),
    .op_en_wr_data     (wdata),
    .op_done           (op_done),
    .err_clr           (err_clr),
    .consumer          (consumer),
    .status_0          (status_0),
    .status_1          (status_1),
    .op_en_0           (op_en_0),
    .op_en_1           (op_en_1),
    .reg_wr_grp_sel    (reg_wr_grp_sel),
    .dp_grp_sel        (dp_grp_sel),
    .dp_op_en          (dp_op_en),
    .dp_op_start       (dp_op_start),
    .done_intr_0       (done_intr_0),
    .done_intr_1       (done_intr_1),
    .err_wr_busy       (err_wr_busy),
    .err_spurious_done (err_spurious_done)
  );

  typedef struct packed {
    logic rstn, prod, wr0, wr1, wd, done, clr;
  } in_t;

  typedef struct packed {
    logic       cons;
    logic [1:0] st0, st1;
    logic       en0, en1, dpen, start, di0, di1, eb, es, rsel, dsel;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  out_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(
    input logic rs, pr, w0, w1, wd, dn, cl,
    input logic cons, input logic [1:0] st0, st1,
    input logic en0, en1, dpen, start, di0, di1, eb, es);
    vec_t v;
    v.i = '{rstn: rs, prod: pr, wr0: w0, wr1: w1, wd: wd, done: dn, clr: cl};
    v.o = '{cons: cons, st0: st0, st1: st1, en0: en0, en1: en1, dpen: dpen,
            start: start, di0: di0, di1: di1, eb: eb, es: es, rsel: pr, dsel: cons};
    return v;
  endfunction

  function automatic out_t sample();
    out_t a;
    a = '{cons: consumer, st0: status_0, st1: status_1, en0: op_en_0, en1: op_en_1,
          dpen: dp_op_en, start: dp_op_start, di0: done_intr_0, di1: done_intr_1,
          eb: err_wr_busy, es: err_spurious_done, rsel: reg_wr_grp_sel, dsel: dp_grp_sel};
    return a;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag, output out_t act);
    out_t exp_o;
    @(negedge clk);
    rstn = v.i.rstn; producer = v.i.prod; wr0 = v.i.wr0; wr1 = v.i.wr1;
    wdata = v.i.wd; op_done = v.i.done; err_clr = v.i.clr;
    sb_q.push_back(v.o);
    @(posedge clk);
    #1;
    exp_o = sb_q.pop_front();
    act   = sample();
    n_chk++;
    if (act !== exp_o) begin
      $display("FAIL %s: got %h required %h", tag, act, exp_o);
    end else begin
      n_pass++;
    end
  endtask

  vec_t tbl[22];

  initial begin
    out_t act;
    int   starts;
    rstn = 1'b0; producer = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    wdata = 1'b0; op_done = 1'b0; err_clr = 1'b0;

    //               rs pr w0 w1 wd dn cl  cons st0 st1 en0 en1 dpen st di0 di1 eb es
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // reset
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // idle
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); // spurious done
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // err_clr
    tbl[4]  = mk(1, 0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0); // enable g0 -> start
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0); // launched
    tbl[6]  = mk(1, 0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0); // busy write g0
    tbl[7]  = mk(1, 1, 0, 1, 0, 0, 0,  0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0); // data-0 write no-op
    tbl[8]  = mk(1, 0, 1, 0, 1, 0, 1,  0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0); // clr beats busy
    tbl[9]  = mk(1, 1, 0, 1, 1, 0, 0,  0, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0); // g1 pending
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0); // back-to-back
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 1, 0, 1, 1, 0,  0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0); // done + wr other
    tbl[13] = mk(1, 0, 1, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); // done + wr consumer
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // clr beats spurious
    tbl[15] = mk(1, 0, 1, 0, 1, 0, 0,  1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // g0 pending
    tbl[16] = mk(1, 1, 0, 1, 1, 0, 0,  1, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0); // g1 running
    tbl[17] = mk(1, 1, 0, 0, 0, 0, 0,  1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0); // g1 done
    tbl[19] = mk(1, 1, 0, 1, 1, 0, 0,  0, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0); // status_1 pending
    tbl[20] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // reset mid-layer
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // done was lost

    for (int k = 0; k < 22; k++) begin
      step(tbl[k], $sformatf("vec%0d", k), act);
    end

    // Hand-written: reset, idle to cycle 10, enable g0; start must pulse once.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seq_rst", act);
    for (int k = 1; k < 10; k++) begin
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seq_idle", act);
    end
    step(mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0), "seq_wr_t10", act);
    starts = int'(act.start);
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "seq_hold", act);
      starts += int'(act.start);
    end
    n_chk++;
    if (starts != 1) begin
      $display("FAIL seq_start_count: got %0d required 1", starts);
    end else begin
      n_pass++;
    end

    // Hand-written: write data 0 to a running group leaves it running, no error.
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0), "seq_wr0_data0", act);
    step(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "seq_done_solo", act);
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seq_intr_clear", act);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
